// File: rtl/recon_pkg.sv
// Shared types for the reconfiguration capture path: status codes, controller
// FSM states and the bitstream slot-table entry.
package recon_pkg;

    localparam int REC_ADDR_W = 34;
    localparam int REC_LEN_W  = 32;

    typedef enum logic [2:0] {
        ST_OK            = 3'd0,
        ST_BAD_ID        = 3'd1,
        ST_NO_SPACE      = 3'd2,
        ST_BAD_SIZE      = 3'd3,
        ST_NOT_COMMITTED = 3'd4,
        ST_DMA_ERR       = 3'd5
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC_LOOKUP,
        S_ALLOC_RSP,
        S_LOAD_LOOKUP,
        S_DMA_ISSUE,
        S_DMA_WAIT,
        S_LOAD_RSP
    } state_e;

    typedef struct packed {
        logic                  alloc;
        logic [REC_ADDR_W-1:0] base;
        logic [REC_ADDR_W:0]   cap;
        logic                  committed;
        logic [REC_LEN_W-1:0]  len;
    } entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is preferred out of reset; the
// pointer only moves when both requesters were competing for the grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (&req) begin
                gnt   = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bitstream_table_ctrl.sv
// Bitstream slot table: hands out aligned DDR slots per id, records committed
// lengths, and turns load commands into one DMA read descriptor each.
module bitstream_table_ctrl
    import recon_pkg::*;
#(
    parameter int              ADDR_WIDTH  = 34,
    parameter int              ID_WIDTH    = 8,
    parameter int              LEN_WIDTH   = 32,
    parameter int              NUM_ENTRIES = 16,
    parameter longint unsigned REGION_BASE = 0,
    parameter longint unsigned REGION_SIZE = 64'h1_0000_0000,
    parameter int unsigned     ALIGN_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req_valid,
    output logic                  alloc_req_ready,
    input  logic [ID_WIDTH-1:0]   alloc_req_id,
    input  logic [LEN_WIDTH-1:0]  alloc_req_size,
    output logic                  alloc_rsp_valid,
    input  logic                  alloc_rsp_ready,
    output logic [ADDR_WIDTH-1:0] alloc_rsp_addr,
    output logic [2:0]            alloc_rsp_status,
    input  logic                  commit_valid,
    input  logic [ID_WIDTH-1:0]   commit_id,
    input  logic [LEN_WIDTH-1:0]  commit_bytes,
    output logic                  commit_err,
    input  logic                  load_req_valid,
    output logic                  load_req_ready,
    input  logic [ID_WIDTH-1:0]   load_req_id,
    output logic                  dma_desc_valid,
    input  logic                  dma_desc_ready,
    output logic [ADDR_WIDTH-1:0] dma_desc_addr,
    output logic [LEN_WIDTH-1:0]  dma_desc_len,
    output logic [ID_WIDTH-1:0]   dma_desc_tag,
    input  logic                  dma_done_valid,
    input  logic                  dma_done_error,
    output logic                  load_done,
    output logic [2:0]            load_status,
    input  logic                  clear,
    output logic                  busy
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int EW = ADDR_WIDTH + 2;
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam logic [CW-1:0] ALIGN_M1   = CW'(ALIGN_BYTES - 1);
    localparam logic [EW-1:0] REGION_END = EW'(REGION_BASE + REGION_SIZE);
    localparam logic [CW-1:0] NF_RESET   = CW'(REGION_BASE);

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   req_id_q, req_id_d;
    logic [LEN_WIDTH-1:0]  req_size_q, req_size_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    status_e               rsp_status_q, rsp_status_d;
    logic [ADDR_WIDTH-1:0] desc_addr_q, desc_addr_d;
    logic [LEN_WIDTH-1:0]  desc_len_q, desc_len_d;
    logic [ID_WIDTH-1:0]   desc_tag_q, desc_tag_d;
    status_e               load_status_q, load_status_d;
    logic                  commit_err_q, commit_err_d;
    logic [CW-1:0]         next_free_q, next_free_d;
    entry_t                tbl_q [NUM_ENTRIES];
    entry_t                tbl_d [NUM_ENTRIES];

    logic          arb_en;
    logic [1:0]    gnt;
    logic [IW-1:0] ridx, cidx;
    entry_t        rent, cent;
    logic [CW-1:0] size_ext, rcap;
    logic [EW-1:0] end_sum;
    logic          alloc_wr, commit_ok;

    function automatic logic id_in_range(input logic [ID_WIDTH-1:0] id);
        return 32'(id) < 32'(NUM_ENTRIES);
    endfunction

    assign arb_en = (state_q == S_IDLE) && !clear;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({load_req_valid, alloc_req_valid}),
        .gnt   (gnt)
    );

    assign ridx     = req_id_q[IW-1:0];
    assign cidx     = commit_id[IW-1:0];
    assign rent     = tbl_q[ridx];
    assign cent     = tbl_q[cidx];
    assign size_ext = CW'(req_size_q);
    assign rcap     = (size_ext + ALIGN_M1) & ~ALIGN_M1;
    assign end_sum  = EW'(next_free_q) + EW'(rcap);

    assign commit_ok = id_in_range(commit_id) && cent.alloc && (commit_bytes != '0)
                       && (CW'(commit_bytes) <= CW'(cent.cap));

    always_comb begin
        state_d       = state_q;
        req_id_d      = req_id_q;
        req_size_d    = req_size_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_status_d  = rsp_status_q;
        desc_addr_d   = desc_addr_q;
        desc_len_d    = desc_len_q;
        desc_tag_d    = desc_tag_q;
        load_status_d = load_status_q;
        commit_err_d  = 1'b0;
        next_free_d   = next_free_q;
        tbl_d         = tbl_q;
        alloc_wr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!clear) begin
                    if (gnt[0]) begin
                        req_id_d   = alloc_req_id;
                        req_size_d = alloc_req_size;
                        state_d    = S_ALLOC_LOOKUP;
                    end else if (gnt[1]) begin
                        req_id_d = load_req_id;
                        state_d  = S_LOAD_LOOKUP;
                    end
                end
            end
            S_ALLOC_LOOKUP: begin
                state_d    = S_ALLOC_RSP;
                rsp_addr_d = '0;
                if (!id_in_range(req_id_q)) begin
                    rsp_status_d = ST_BAD_ID;
                end else if (req_size_q == '0) begin
                    rsp_status_d = ST_BAD_SIZE;
                end else if (rent.alloc) begin
                    // Re-allocation reuses the slot if the new image still fits.
                    if (size_ext <= CW'(rent.cap)) begin
                        rsp_status_d = ST_OK;
                        rsp_addr_d   = ADDR_WIDTH'(rent.base);
                        alloc_wr     = 1'b1;
                    end else begin
                        rsp_status_d = ST_BAD_SIZE;
                    end
                end else if (end_sum > REGION_END) begin
                    rsp_status_d = ST_NO_SPACE;
                end else begin
                    rsp_status_d      = ST_OK;
                    rsp_addr_d        = next_free_q[ADDR_WIDTH-1:0];
                    alloc_wr          = 1'b1;
                    tbl_d[ridx].alloc = 1'b1;
                    tbl_d[ridx].base  = REC_ADDR_W'(next_free_q[ADDR_WIDTH-1:0]);
                    tbl_d[ridx].cap   = (REC_ADDR_W+1)'(rcap);
                    next_free_d       = next_free_q + rcap;
                end
                if (alloc_wr) tbl_d[ridx].committed = 1'b0;
            end
            S_ALLOC_RSP: begin
                if (alloc_rsp_ready) state_d = S_IDLE;
            end
            S_LOAD_LOOKUP: begin
                if (!id_in_range(req_id_q)) begin
                    load_status_d = ST_BAD_ID;
                    state_d       = S_LOAD_RSP;
                end else if (!rent.committed) begin
                    load_status_d = ST_NOT_COMMITTED;
                    state_d       = S_LOAD_RSP;
                end else begin
                    desc_addr_d = ADDR_WIDTH'(rent.base);
                    desc_len_d  = LEN_WIDTH'(rent.len);
                    desc_tag_d  = req_id_q;
                    state_d     = S_DMA_ISSUE;
                end
            end
            S_DMA_ISSUE: begin
                if (dma_desc_ready) state_d = S_DMA_WAIT;
            end
            S_DMA_WAIT: begin
                if (dma_done_valid) begin
                    load_status_d = dma_done_error ? ST_DMA_ERR : ST_OK;
                    state_d       = S_LOAD_RSP;
                end
            end
            S_LOAD_RSP: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // A commit racing an allocation write to the same id would see stale cap.
        if (commit_valid) begin
            if (commit_ok && !(alloc_wr && (commit_id == req_id_q))) begin
                tbl_d[cidx].committed = 1'b1;
                tbl_d[cidx].len       = REC_LEN_W'(commit_bytes);
            end else begin
                commit_err_d = 1'b1;
            end
        end

        if ((state_q == S_IDLE) && clear) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_d[i].alloc     = 1'b0;
                tbl_d[i].committed = 1'b0;
            end
            next_free_d = NF_RESET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_id_q      <= '0;
            req_size_q    <= '0;
            rsp_addr_q    <= '0;
            rsp_status_q  <= ST_OK;
            desc_addr_q   <= '0;
            desc_len_q    <= '0;
            desc_tag_q    <= '0;
            load_status_q <= ST_OK;
            commit_err_q  <= 1'b0;
            next_free_q   <= NF_RESET;
            for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            req_id_q      <= req_id_d;
            req_size_q    <= req_size_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_status_q  <= rsp_status_d;
            desc_addr_q   <= desc_addr_d;
            desc_len_q    <= desc_len_d;
            desc_tag_q    <= desc_tag_d;
            load_status_q <= load_status_d;
            commit_err_q  <= commit_err_d;
            next_free_q   <= next_free_d;
            for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= tbl_d[i];
        end
    end

    assign alloc_req_ready  = gnt[0];
    assign load_req_ready   = gnt[1];
    assign alloc_rsp_valid  = (state_q == S_ALLOC_RSP);
    assign alloc_rsp_addr   = rsp_addr_q;
    assign alloc_rsp_status = rsp_status_q;
    assign dma_desc_valid   = (state_q == S_DMA_ISSUE);
    assign dma_desc_addr    = desc_addr_q;
    assign dma_desc_len     = desc_len_q;
    assign dma_desc_tag     = desc_tag_q;
    assign load_done        = (state_q == S_LOAD_RSP);
    assign load_status      = load_status_q;
    assign commit_err       = commit_err_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_bitstream_table_ctrl.sv
// Directed scoreboard bench for bitstream_table_ctrl on a 64 KiB region with
// 4 KiB slots and 16 entries.
module tb_bitstream_table_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_req_valid, alloc_req_ready;
    logic [7:0]  alloc_req_id;
    logic [31:0] alloc_req_size;
    logic        alloc_rsp_valid, alloc_rsp_ready;
    logic [33:0] alloc_rsp_addr;
    logic [2:0]  alloc_rsp_status;
    logic        commit_valid;
    logic [7:0]  commit_id;
    logic [31:0] commit_bytes;
    logic        commit_err;
    logic        load_req_valid, load_req_ready;
    logic [7:0]  load_req_id;
    logic        dma_desc_valid, dma_desc_ready;
    logic [33:0] dma_desc_addr;
    logic [31:0] dma_desc_len;
    logic [7:0]  dma_desc_tag;
    logic        dma_done_valid, dma_done_error;
    logic        load_done;
    logic [2:0]  load_status;
    logic        clear, busy;

    always #5 clk = ~clk;

    bitstream_table_ctrl #(
        .ADDR_WIDTH(34), .ID_WIDTH(8), .LEN_WIDTH(32), .NUM_ENTRIES(16),
        .REGION_BASE(0), .REGION_SIZE(64'h1_0000), .ALIGN_BYTES(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req_valid(alloc_req_valid), .alloc_req_ready(alloc_req_ready),
        .alloc_req_id(alloc_req_id), .alloc_req_size(alloc_req_size),
        .alloc_rsp_valid(alloc_rsp_valid), .alloc_rsp_ready(alloc_rsp_ready),
        .alloc_rsp_addr(alloc_rsp_addr), .alloc_rsp_status(alloc_rsp_status),
        .commit_valid(commit_valid), .commit_id(commit_id),
        .commit_bytes(commit_bytes), .commit_err(commit_err),
        .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
        .load_req_id(load_req_id),
        .dma_desc_valid(dma_desc_valid), .dma_desc_ready(dma_desc_ready),
        .dma_desc_addr(dma_desc_addr), .dma_desc_len(dma_desc_len),
        .dma_desc_tag(dma_desc_tag),
        .dma_done_valid(dma_done_valid), .dma_done_error(dma_done_error),
        .load_done(load_done), .load_status(load_status),
        .clear(clear), .busy(busy)
    );

    typedef struct { logic [33:0] addr; logic [2:0] st; } aexp_t;
    typedef struct { logic [33:0] addr; logic [31:0] len; logic [7:0] tag; } dexp_t;

    aexp_t      q_alloc[$];
    logic [2:0] q_load[$];
    dexp_t      q_desc[$];

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] OK = 3'd0, BAD_ID = 3'd1, NO_SPACE = 3'd2, BAD_SIZE = 3'd3,
                           NOT_COMMITTED = 3'd4, DMA_ERR = 3'd5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (alloc_rsp_valid && alloc_rsp_ready) begin
            if (q_alloc.size() == 0) chk("alloc_unexpected", alloc_rsp_valid, 0);
            else begin
                aexp_t e;
                e = q_alloc.pop_front();
                chk("alloc_addr", alloc_rsp_addr, e.addr);
                chk("alloc_status", alloc_rsp_status, e.st);
            end
        end
    end

    always @(negedge clk) begin
        if (load_done) begin
            if (q_load.size() == 0) chk("load_unexpected", load_done, 0);
            else begin
                logic [2:0] e;
                e = q_load.pop_front();
                chk("load_status", load_status, e);
            end
        end
    end

    always @(negedge clk) begin
        if (dma_desc_valid) begin
            if (q_desc.size() == 0) chk("desc_unexpected", dma_desc_valid, 0);
            else if (dma_desc_ready) begin
                dexp_t e;
                e = q_desc.pop_front();
                chk("desc_addr", dma_desc_addr, e.addr);
                chk("desc_len", dma_desc_len, e.len);
                chk("desc_tag", dma_desc_tag, e.tag);
            end
        end
    end

    task automatic accept_alloc(input logic [7:0] id, input logic [31:0] sz);
        int n = 0;
        @(posedge clk); #1;
        alloc_req_valid = 1; alloc_req_id = id; alloc_req_size = sz;
        do begin @(negedge clk); n++; end while (!alloc_req_ready && n < 50);
        chk("alloc_accept", alloc_req_ready, 1);
        @(posedge clk); #1 alloc_req_valid = 0;
    endtask

    task automatic accept_load(input logic [7:0] id);
        int n = 0;
        @(posedge clk); #1;
        load_req_valid = 1; load_req_id = id;
        do begin @(negedge clk); n++; end while (!load_req_ready && n < 50);
        chk("load_accept", load_req_ready, 1);
        @(posedge clk); #1 load_req_valid = 0;
    endtask

    task automatic do_alloc(input logic [7:0] id, input logic [31:0] sz,
                            input logic [33:0] ea, input logic [2:0] es);
        int n = 0;
        q_alloc.push_back('{ea, es});
        accept_alloc(id, sz);
        do begin @(negedge clk); n++; end while (!alloc_rsp_valid && n < 20);
        chk("alloc_latency", n, 2);
        for (int i = 0; i < 20 && q_alloc.size() != 0; i++) @(negedge clk);
        chk("alloc_drain", q_alloc.size(), 0);
    endtask

    task automatic do_commit(input logic [7:0] id, input logic [31:0] bytes, input logic exp_err);
        @(posedge clk); #1;
        commit_valid = 1; commit_id = id; commit_bytes = bytes;
        @(posedge clk); #1 commit_valid = 0;
        @(negedge clk);
        chk("commit_err", commit_err, exp_err);
        @(negedge clk);
        chk("commit_err_pulse", commit_err, 0);
    endtask

    task automatic do_load(input logic [7:0] id, input logic [2:0] st, input bit has_desc,
                           input logic [33:0] a, input logic [31:0] l, input int stall,
                           input bit derr);
        int n = 0;
        q_load.push_back(st);
        if (has_desc) q_desc.push_back('{a, l, id});
        accept_load(id);
        if (has_desc) begin
            do begin @(negedge clk); n++; end while (!dma_desc_valid && n < 20);
            chk("desc_latency", n, 2);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall_valid", dma_desc_valid, 1);
                chk("stall_addr", dma_desc_addr, a);
                chk("stall_len", dma_desc_len, l);
                chk("stall_tag", dma_desc_tag, id);
            end
            @(posedge clk); #1 dma_desc_ready = 1;
            @(posedge clk); #1 dma_desc_ready = 0;
            repeat (3) @(posedge clk);
            #1 dma_done_valid = 1; dma_done_error = derr;
            @(posedge clk); #1 dma_done_valid = 0; dma_done_error = 0;
            @(negedge clk);
            chk("done_latency", load_done, 1);
        end else begin
            do begin @(negedge clk); n++; end while (!load_done && n < 20);
            chk("err_load_latency", n, 2);
        end
        for (int i = 0; i < 20 && q_load.size() != 0; i++) @(negedge clk);
        chk("load_drain", q_load.size(), 0);
    endtask

    initial begin
        int n;
        rst_n = 0;
        alloc_req_valid = 0; alloc_req_id = 0; alloc_req_size = 0; alloc_rsp_ready = 1;
        commit_valid = 0; commit_id = 0; commit_bytes = 0;
        load_req_valid = 0; load_req_id = 0;
        dma_desc_ready = 0; dma_done_valid = 0; dma_done_error = 0; clear = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", alloc_rsp_valid, 0);
        chk("rst_desc_valid", dma_desc_valid, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_commit_err", commit_err, 0);
        chk("rst_rsp_addr", alloc_rsp_addr, 0);
        @(posedge clk); #1 rst_n = 1;

        // 1: fresh allocations
        do_alloc(8'd3, 32'h1800, 34'h0, OK);
        do_alloc(8'd5, 32'h1, 34'h2000, OK);
        // 2: region exhaustion and re-allocation limits
        do_alloc(8'd7, 32'hE000, 34'h0, NO_SPACE);
        do_alloc(8'd7, 32'hD000, 34'h3000, OK);
        do_alloc(8'd3, 32'h3000, 34'h0, BAD_SIZE);
        // 3: load before/after commit, stalled descriptor
        do_load(8'd3, NOT_COMMITTED, 0, 0, 0, 0, 0);
        do_commit(8'd3, 32'h1800, 0);
        do_load(8'd3, OK, 1, 34'h0, 32'h1800, 5, 0);

        // 4: simultaneous requests, pointer alternates
        q_alloc.push_back('{34'h2000, OK});
        q_load.push_back(NOT_COMMITTED);
        @(posedge clk); #1;
        alloc_req_valid = 1; alloc_req_id = 8'd5; alloc_req_size = 32'h1;
        load_req_valid = 1; load_req_id = 8'd12;
        @(negedge clk);
        chk("rr1_alloc_ready", alloc_req_ready, 1);
        chk("rr1_load_ready", load_req_ready, 0);
        @(posedge clk); #1 alloc_req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!load_req_ready && n < 50);
        chk("rr1_alloc_first", q_alloc.size(), 0);
        @(posedge clk); #1 load_req_valid = 0;
        for (int i = 0; i < 20 && q_load.size() != 0; i++) @(negedge clk);
        chk("rr1_load_drain", q_load.size(), 0);

        q_load.push_back(NOT_COMMITTED);
        q_alloc.push_back('{34'h2000, OK});
        @(posedge clk); #1;
        alloc_req_valid = 1; load_req_valid = 1;
        @(negedge clk);
        chk("rr2_load_ready", load_req_ready, 1);
        chk("rr2_alloc_ready", alloc_req_ready, 0);
        @(posedge clk); #1 load_req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!alloc_req_ready && n < 50);
        chk("rr2_load_first", q_load.size(), 0);
        @(posedge clk); #1 alloc_req_valid = 0;
        for (int i = 0; i < 20 && q_alloc.size() != 0; i++) @(negedge clk);
        chk("rr2_alloc_drain", q_alloc.size(), 0);
        do_commit(8'd9, 32'h100, 1);

        // 5: reset while waiting on the DMA engine
        q_desc.push_back('{34'h0, 32'h1800, 8'd3});
        accept_load(8'd3);
        n = 0;
        do begin @(negedge clk); n++; end while (!dma_desc_valid && n < 20);
        chk("s5_desc_valid", dma_desc_valid, 1);
        @(posedge clk); #1 dma_desc_ready = 1;
        @(posedge clk); #1 dma_desc_ready = 0;
        repeat (2) @(posedge clk);
        #1 chk("s5_busy_in_wait", busy, 1);
        rst_n = 0;
        #1;
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_desc_valid", dma_desc_valid, 0);
        chk("s5_rst_load_done", load_done, 0);
        chk("s5_rst_rsp_valid", alloc_rsp_valid, 0);
        chk("s5_rst_desc_addr", dma_desc_addr, 0);
        @(posedge clk); #1 rst_n = 1;
        do_load(8'd3, NOT_COMMITTED, 0, 0, 0, 0, 0);
        do_alloc(8'd3, 32'h1800, 34'h0, OK);

        // 6: bad id, DMA error, commit limits, clear
        do_alloc(8'd16, 32'h1000, 34'h0, BAD_ID);
        do_alloc(8'd5, 32'h1, 34'h2000, OK);
        do_commit(8'd5, 32'h800, 0);
        do_commit(8'd3, 32'h2001, 1);
        do_commit(8'd3, 32'h0, 1);
        do_load(8'd5, DMA_ERR, 1, 34'h2000, 32'h800, 0, 1);
        @(posedge clk); #1 clear = 1;
        @(posedge clk); #1 clear = 0;
        do_load(8'd5, NOT_COMMITTED, 0, 0, 0, 0, 0);
        do_alloc(8'd7, 32'h1000, 34'h0, OK);

        repeat (3) @(negedge clk);
        chk("final_desc_queue", q_desc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
